reg_file_ctrl: RTL and testbench

REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

---
 rtl/reg_file_ctrl_pkg.sv | 35 +++
 rtl/reg_file_ctrl.sv | 113 +++++++++++
 tb/tb_reg_file_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_ctrl_pkg.sv
// Shared encodings and defaults for the register-file command controller.
// State set grows by VRD/VRD_WAIT when REG_FILE_CTRL_WRITE_VERIFY_EN is defined.
package reg_file_ctrl_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ADDR_WIDTH_DEF = 3;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR       = 3'd1,
      ST_RD       = 3'd2,
      ST_RD_WAIT  = 3'd3,
      ST_RSP      = 3'd4,
      ST_VRD      = 3'd5,
      ST_VRD_WAIT = 3'd6
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
`else
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR       = 3'd1,
      ST_RD       = 3'd2,
      ST_RD_WAIT  = 3'd3,
      ST_RSP      = 3'd4
   } state_t;
`endif

endpackage

// File: rtl/reg_file_ctrl.sv
// Command/response front end for a sync-read register file: read rsp at k+3, write rsp at k+2 (k+4 with verify).
// One command in flight; Rsp_Ready low parks the FSM in RSP with no strobes. Option: REG_FILE_CTRL_WRITE_VERIFY_EN.
module reg_file_ctrl
   import reg_file_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Cmd_Valid,
   output logic                  Cmd_Ready,
   input  logic                  Cmd_Op,
   input  logic [ADDR_WIDTH-1:0] Cmd_Addr,
   input  logic [DATA_WIDTH-1:0] Cmd_Data,
   output logic                  Rsp_Valid,
   input  logic                  Rsp_Ready,
   output logic [DATA_WIDTH-1:0] Rsp_Data,
   output logic                  Rsp_Err,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WrData,
`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
   output logic [7:0]            Err_Count,
`endif
   input  logic [DATA_WIDTH-1:0] RdData
);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [DATA_WIDTH-1:0]   rsp_data_q;
`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
   logic                    rsp_err_q;
   logic [7:0]              err_count_q;
`endif

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= ST_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         rsp_data_q <= '0;
`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
         rsp_err_q   <= 1'b0;
         err_count_q <= 8'd0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (Cmd_Valid) begin
                  addr_q <= Cmd_Addr;
                  data_q <= Cmd_Data;
                  state  <= (Cmd_Op == OP_WRITE) ? ST_WR : ST_RD;
               end
            end
            ST_WR: begin
`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
               state <= ST_VRD;
`else
               rsp_data_q <= '0;
               state      <= ST_RSP;
`endif
            end
            ST_RD: begin
               state <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               rsp_data_q <= RdData;
`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
               rsp_err_q  <= 1'b0;
`endif
               state      <= ST_RSP;
            end
`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
            ST_VRD: begin
               state <= ST_VRD_WAIT;
            end
            ST_VRD_WAIT: begin
               rsp_data_q <= RdData;
               rsp_err_q  <= (RdData != data_q);
               if (RdData != data_q)
                  err_count_q <= sat_inc8(err_count_q);
               state <= ST_RSP;
            end
`endif
            ST_RSP: begin
               if (Rsp_Ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Ready also drops while reset is held so nothing is accepted during reset.
   assign Cmd_Ready = RST && (state == ST_IDLE);
   assign Rsp_Valid = (state == ST_RSP);
   assign WrEn      = (state == ST_WR);
`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
   assign RdEn      = (state == ST_RD) || (state == ST_VRD);
   assign Rsp_Err   = rsp_err_q;
   assign Err_Count = err_count_q;
`else
   assign RdEn      = (state == ST_RD);
   assign Rsp_Err   = 1'b0;
`endif
   assign Address   = addr_q;
   assign WrData    = data_q;
   assign Rsp_Data  = rsp_data_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Randomized and directed bench for reg_file_ctrl against an array-based register model.
module tb_reg_file_ctrl;
   import reg_file_ctrl_pkg::*;

`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
   localparam bit VERIFY = 1'b1;
   localparam int WR_LAT = 4;
`else
   localparam bit VERIFY = 1'b0;
   localparam int WR_LAT = 2;
`endif
   localparam int RD_LAT = 3;

   logic        CLK = 1'b0;
   logic        RST;
   logic        Cmd_Valid, Cmd_Ready, Cmd_Op;
   logic [2:0]  Cmd_Addr;
   logic [15:0] Cmd_Data;
   logic        Rsp_Valid, Rsp_Ready, Rsp_Err;
   logic [15:0] Rsp_Data;
   logic        WrEn, RdEn;
   logic [2:0]  Address;
   logic [15:0] WrData;
   logic [15:0] RdData;
`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
   logic [7:0]  Err_Count;
`endif

   reg_file_ctrl dut (
      .CLK(CLK), .RST(RST),
      .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op),
      .Cmd_Addr(Cmd_Addr), .Cmd_Data(Cmd_Data),
      .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Data(Rsp_Data), .Rsp_Err(Rsp_Err),
      .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
      .Err_Count(Err_Count),
`endif
      .RdData(RdData)
   );

   always #5 CLK = ~CLK;

   // External register file with synchronous read and an optional forced readback.
   logic [15:0] rf [8];
   bit          force_rb_en = 1'b0;
   logic [15:0] force_rb_val = 16'h0;
   always @(posedge CLK) begin
      if (WrEn) rf[Address] <= WrData;
      if (RdEn) RdData <= force_rb_en ? force_rb_val : rf[Address];
   end

   int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
   logic [2:0]  last_wa;
   logic [15:0] last_wd;
   always @(negedge CLK) begin
      if (WrEn) begin wr_cnt++; last_wa = Address; last_wd = WrData; end
      if (RdEn) rd_cnt++;
      if (WrEn && RdEn) both_cnt++;
   end

   logic [15:0] mem_m [8];
   int n_cmp = 0, n_fail = 0;

   // Presents one command, waits for its response with Rsp_Ready high; lat=99 on timeout.
   task automatic do_cmd(input logic op, input logic [2:0] a, input logic [15:0] d,
                         output logic [15:0] rdata, output logic rerr, output int lat);
      int w = 0;
      Cmd_Op = op; Cmd_Addr = a; Cmd_Data = d; Cmd_Valid = 1'b1; Rsp_Ready = 1'b1;
      while (!Cmd_Ready && w < 20) begin @(negedge CLK); w++; end
      @(negedge CLK);
      Cmd_Valid = 1'b0;
      lat = 1;
      while (!Rsp_Valid && lat < 20) begin @(negedge CLK); lat++; end
      rdata = Rsp_Data; rerr = Rsp_Err;
      if (!Rsp_Valid || w >= 20) lat = 99;
      @(negedge CLK);
   endtask

   task automatic apply_reset(input int cycles);
      RST = 1'b0;
      repeat (cycles) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      n_cmp++;
      if ({Cmd_Ready, Rsp_Valid, WrEn, RdEn, Rsp_Err} !== 5'b0 || Address !== 3'd0 ||
          WrData !== 16'h0 || Rsp_Data !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b we=%b re=%b err=%b addr=%h wd=%h rd=%h required all 0",
                  Cmd_Ready, Rsp_Valid, WrEn, RdEn, Rsp_Err, Address, WrData, Rsp_Data);
      end
      RST = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (Cmd_Ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b required 1", Cmd_Ready);
      end
   endtask

   task automatic test_write_read();
      logic [15:0] rd; logic re; int lat; int w0;
      w0 = wr_cnt;
      do_cmd(OP_WRITE, 3'd5, 16'hA5A5, rd, re, lat);
      mem_m[5] = 16'hA5A5;
      n_cmp++;
      if (wr_cnt - w0 !== 1 || last_wa !== 3'd5 || last_wd !== 16'hA5A5) begin
         n_fail++; $display("FAIL wr_strobe: got pulses=%0d addr=%h data=%h required 1/5/a5a5",
                            wr_cnt - w0, last_wa, last_wd);
      end
      n_cmp++;
      if (lat !== WR_LAT) begin n_fail++; $display("FAIL wr_latency: got %0d required %0d", lat, WR_LAT); end
      n_cmp++;
      if (rd !== (VERIFY ? 16'hA5A5 : 16'h0) || re !== 1'b0) begin
         n_fail++; $display("FAIL wr_rsp: got %h/%b required %h/0", rd, re, VERIFY ? 16'hA5A5 : 16'h0);
      end
      do_cmd(OP_READ, 3'd5, 16'hFFFF, rd, re, lat);
      n_cmp++;
      if (rd !== 16'hA5A5 || lat !== RD_LAT) begin
         n_fail++; $display("FAIL rd_a5a5: got %h lat %0d required a5a5 lat %0d", rd, lat, RD_LAT);
      end
   endtask

   task automatic test_addr_wrap();
      logic [15:0] rd; logic re; int lat;
      do_cmd(OP_WRITE, 3'd7, 16'h7E57, rd, re, lat); mem_m[7] = 16'h7E57;
      do_cmd(OP_WRITE, 3'd0, 16'h0F0F, rd, re, lat); mem_m[0] = 16'h0F0F;
      n_cmp++;
      if (last_wa !== 3'd0) begin n_fail++; $display("FAIL wrap_addr0: got %h required 0", last_wa); end
      do_cmd(OP_READ, 3'd7, 16'h0, rd, re, lat);
      n_cmp++;
      if (rd !== mem_m[7]) begin n_fail++; $display("FAIL wrap_rd7: got %h required %h", rd, mem_m[7]); end
   endtask

   task automatic test_backpressure();
      logic [15:0] held; int w = 0; int w0, r0;
      Cmd_Op = OP_READ; Cmd_Addr = 3'd7; Cmd_Data = 16'h0; Cmd_Valid = 1'b1; Rsp_Ready = 1'b0;
      while (!Cmd_Ready && w < 20) begin @(negedge CLK); w++; end
      @(negedge CLK);
      Cmd_Valid = 1'b0;
      w = 0;
      while (!Rsp_Valid && w < 20) begin @(negedge CLK); w++; end
      held = Rsp_Data;
      n_cmp++;
      if (Rsp_Valid !== 1'b1 || held !== mem_m[7]) begin
         n_fail++; $display("FAIL bp_first: got vld=%b data=%h required 1/%h", Rsp_Valid, held, mem_m[7]);
      end
      w0 = wr_cnt; r0 = rd_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         n_cmp++;
         if (Rsp_Valid !== 1'b1 || Rsp_Data !== held || Cmd_Ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_stall[%0d]: got vld=%b data=%h rdy=%b required 1/%h/0",
                               i, Rsp_Valid, Rsp_Data, Cmd_Ready, held);
         end
      end
      n_cmp++;
      if (wr_cnt !== w0 || rd_cnt !== r0) begin
         n_fail++; $display("FAIL bp_strobes: got wr+%0d rd+%0d required 0/0", wr_cnt - w0, rd_cnt - r0);
      end
      Rsp_Ready = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (Rsp_Valid !== 1'b0 || Cmd_Ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b required 0/1", Rsp_Valid, Cmd_Ready);
      end
   endtask

   task automatic test_back_to_back();
      logic        op [4];
      logic [2:0]  ad [4];
      logic [15:0] dt [4];
      logic [15:0] exp_q[$];
      logic [15:0] got_q[$];
      int idx = 0; bit pend = 0; int b0 = both_cnt;
      op[0] = OP_WRITE; ad[0] = 3'd1; dt[0] = 16'($urandom);
      op[1] = OP_READ;  ad[1] = 3'd1; dt[1] = 16'($urandom);
      op[2] = OP_WRITE; ad[2] = 3'd6; dt[2] = 16'($urandom);
      op[3] = OP_READ;  ad[3] = 3'd7; dt[3] = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
         if (op[i] == OP_WRITE) begin mem_m[ad[i]] = dt[i]; exp_q.push_back(VERIFY ? dt[i] : 16'h0); end
         else exp_q.push_back(mem_m[ad[i]]);
      end
      Rsp_Ready = 1'b1;
      for (int c = 0; c < 60 && got_q.size() < 4; c++) begin
         if (Rsp_Valid) got_q.push_back(Rsp_Data);
         if (pend) idx++;
         if (idx < 4) begin
            Cmd_Valid = 1'b1; Cmd_Op = op[idx]; Cmd_Addr = ad[idx]; Cmd_Data = dt[idx];
         end else Cmd_Valid = 1'b0;
         pend = Cmd_Valid && Cmd_Ready;
         @(negedge CLK);
      end
      Cmd_Valid = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if (got_q.size() !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d required 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL b2b_rsp[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (both_cnt !== b0) begin n_fail++; $display("FAIL b2b_both_strobes: got %0d required 0", both_cnt - b0); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rd; logic re; int lat; int w = 0; int r0; bit saw_vld = 0;
      Cmd_Op = OP_READ; Cmd_Addr = 3'd5; Cmd_Valid = 1'b1; Rsp_Ready = 1'b1;
      while (!Cmd_Ready && w < 20) begin @(negedge CLK); w++; end
      r0 = rd_cnt;
      @(negedge CLK);
      Cmd_Valid = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if ({Cmd_Ready, Rsp_Valid, WrEn, RdEn, Rsp_Err} !== 5'b0 || Address !== 3'd0 ||
          WrData !== 16'h0 || Rsp_Data !== 16'h0) begin
         n_fail++; $display("FAIL midrst_outputs: got rdy=%b vld=%b we=%b re=%b addr=%h wd=%h rd=%h required all 0",
                            Cmd_Ready, Rsp_Valid, WrEn, RdEn, Address, WrData, Rsp_Data);
      end
      RST = 1'b1;
      for (int i = 0; i < 5; i++) begin @(negedge CLK); if (Rsp_Valid) saw_vld = 1; end
      n_cmp++;
      if (saw_vld !== 1'b0 || rd_cnt - r0 !== 1) begin
         n_fail++; $display("FAIL midrst_abandon: got vld=%b rd_pulses=%0d required 0/1", saw_vld, rd_cnt - r0);
      end
      do_cmd(OP_READ, 3'd5, 16'h0, rd, re, lat);
      n_cmp++;
      if (rd !== mem_m[5] || lat !== RD_LAT) begin
         n_fail++; $display("FAIL midrst_recover: got %h lat %0d required %h lat %0d", rd, lat, mem_m[5], RD_LAT);
      end
   endtask

   task automatic test_random();
      logic [15:0] rd, exp_d; logic re; int lat, exp_lat;
      logic op; logic [2:0] a; logic [15:0] d;
      for (int i = 0; i < 40; i++) begin
         op = 1'($urandom_range(0, 1)); a = 3'($urandom_range(0, 7)); d = 16'($urandom);
         if (op == OP_WRITE) begin mem_m[a] = d; exp_d = VERIFY ? d : 16'h0; exp_lat = WR_LAT; end
         else begin exp_d = mem_m[a]; exp_lat = RD_LAT; end
         do_cmd(op, a, d, rd, re, lat);
         n_cmp++;
         if (rd !== exp_d || re !== 1'b0 || lat !== exp_lat) begin
            n_fail++; $display("FAIL rand[%0d] op=%b a=%0d: got %h/%b lat %0d required %h/0 lat %0d",
                               i, op, a, rd, re, lat, exp_d, exp_lat);
         end
      end
   endtask

`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
   task automatic test_verify_err();
      logic [15:0] rd; logic re; int lat;
      apply_reset(2);
      force_rb_en = 1'b1; force_rb_val = 16'h0001;
      do_cmd(OP_WRITE, 3'd2, 16'h0000, rd, re, lat);
      force_rb_en = 1'b0; mem_m[2] = 16'h0000;
      n_cmp++;
      if (re !== 1'b1 || rd !== 16'h0001 || Err_Count !== 8'd1) begin
         n_fail++; $display("FAIL verify_mismatch: got err=%b data=%h cnt=%0d required 1/0001/1", re, rd, Err_Count);
      end
   endtask

   task automatic test_err_sat();
      logic [15:0] rd, d; logic re; int lat;
      apply_reset(2);
      force_rb_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         d = 16'($urandom); force_rb_val = ~d;
         do_cmd(OP_WRITE, 3'd3, d, rd, re, lat);
         mem_m[3] = d;
      end
      force_rb_en = 1'b0;
      n_cmp++;
      if (Err_Count !== 8'd255) begin n_fail++; $display("FAIL err_sat: got %0d required 255", Err_Count); end
   endtask
`endif

   initial begin
      RST = 1'b0; Cmd_Valid = 1'b0; Cmd_Op = 1'b0; Cmd_Addr = 3'd0; Cmd_Data = 16'h0; Rsp_Ready = 1'b1;
      for (int i = 0; i < 8; i++) begin rf[i] = 16'h0; mem_m[i] = 16'h0; end
      @(negedge CLK);
      test_reset();
      test_write_read();
      test_addr_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef REG_FILE_CTRL_WRITE_VERIFY_EN
      test_verify_err();
      test_err_sat();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
